// File: rtl/dmem_responder.sv
// Data-memory responder for the memory stage: one load/store at a time, fixed
// access latency, zero-fill sweep of the backing store after every reset.
module dmem_responder #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   input  logic [3:0]  req_tag,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_rdata,
   output logic [3:0]  rsp_tag,
   output logic        rsp_we,
   output logic        rsp_err,
   output logic        init_done
);

   localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [16:0]   DEPTH_W  = 17'(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
   localparam logic [3:0]    LAT_INIT = 4'(LATENCY);

   localparam logic [1:0] ST_INIT = 2'd0;
   localparam logic [1:0] ST_IDLE = 2'd1;
   localparam logic [1:0] ST_BUSY = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   logic [1:0]    state_q,     state_d;
   logic [AW-1:0] init_ptr_q,  init_ptr_d;
   logic [3:0]    cnt_q,       cnt_d;
   logic          we_q,        we_d;
   logic [15:0]   addr_q,      addr_d;
   logic [15:0]   wdata_q,     wdata_d;
   logic [3:0]    tag_q,       tag_d;
   logic          req_ready_q, req_ready_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [15:0]   rsp_rdata_q, rsp_rdata_d;
   logic [3:0]    rsp_tag_q,   rsp_tag_d;
   logic          rsp_we_q,    rsp_we_d;
   logic          rsp_err_q,   rsp_err_d;
   logic          init_done_q, init_done_d;

   logic [15:0]   mem_q [DEPTH];
   logic          mem_we;
   logic [AW-1:0] mem_idx;
   logic [15:0]   mem_wdata;
   logic          in_range;

   // Widened compare so DEPTH=65536 still works with a 16-bit address.
   assign in_range = ({1'b0, addr_q} < DEPTH_W);

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      init_ptr_d  = init_ptr_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      tag_d       = tag_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_tag_d   = rsp_tag_q;
      rsp_we_d    = rsp_we_q;
      rsp_err_d   = rsp_err_q;
      init_done_d = init_done_q;
      mem_we      = 1'b0;
      mem_idx     = addr_q[AW-1:0];
      mem_wdata   = wdata_q;

      case (state_q)
         ST_INIT: begin
            mem_we     = 1'b1;
            mem_idx    = init_ptr_q;
            mem_wdata  = '0;
            init_ptr_d = init_ptr_q + AW'(1);
            if (init_ptr_q == LAST_IDX) begin
               state_d     = ST_IDLE;
               req_ready_d = 1'b1;
               init_done_d = 1'b1;
            end
         end

         ST_IDLE: begin
            if (req_valid) begin
               we_d        = req_we;
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               tag_d       = req_tag;
               cnt_d       = LAT_INIT;
               req_ready_d = 1'b0;
               state_d     = ST_BUSY;
            end
         end

         ST_BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               mem_we      = we_q && in_range;
               rsp_rdata_d = (!we_q && in_range) ? mem_q[addr_q[AW-1:0]] : 16'h0000;
               rsp_tag_d   = tag_q;
               rsp_we_d    = we_q;
               rsp_err_d   = !in_range;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end
         end

         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d    = ST_INIT;
            init_ptr_d = '0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of block ordering.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_INIT;
         init_ptr_q  <= '0;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         tag_q       <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_tag_q   <= '0;
         rsp_we_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_ptr_q  <= init_ptr_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         tag_q       <= tag_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_tag_q   <= rsp_tag_d;
         rsp_we_q    <= rsp_we_d;
         rsp_err_q   <= rsp_err_d;
         init_done_q <= init_done_d;
      end
   end

   // NOTE: the array has no reset branch so it maps onto RAM; the INIT sweep
   // zero-fills it instead. A store caught by reset is simply not written.
   always_ff @(posedge clk) begin
      if (reset && mem_we) begin
         mem_q[mem_idx] <= mem_wdata;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_tag   = rsp_tag_q;
   assign rsp_we    = rsp_we_q;
   assign rsp_err   = rsp_err_q;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected
// responses; a negedge monitor pops and compares on every handshake.
module tb_dmem_responder;

   localparam int DEPTH   = 16;
   localparam int LATENCY = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic [3:0]  req_tag;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_rdata;
   logic [3:0]  rsp_tag;
   logic        rsp_we;
   logic        rsp_err;
   logic        init_done;

   typedef struct packed {
      logic [15:0] rdata;
      logic [3:0]  tag;
      logic        we;
      logic        err;
   } rsp_t;

   rsp_t exp_q[$];
   rsp_t mon_exp;
   int   compared   = 0;
   int   mismatched = 0;

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_tag   (req_tag),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_tag   (rsp_tag),
      .rsp_we    (rsp_we),
      .rsp_err   (rsp_err),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every accepted response must match the oldest expectation.
   always @(negedge clk) begin
      if (reset === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("rsp", 32'({rsp_rdata, rsp_tag, rsp_we, rsp_err}), 32'(mon_exp));
         end
      end
   end

   task automatic wait_ready(input string name);
      int t = 0;
      while (req_ready !== 1'b1 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (req_ready !== 1'b1) check(name, 32'(req_ready), 32'd1);
   endtask

   // Issue one request and return once rsp_valid is seen (cycle 3 after accept).
   task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [3:0] tag, input logic [15:0] exp_rdata, input logic exp_err);
      int k;
      rsp_t e;
      wait_ready("req_ready_timeout");
      e.rdata = exp_rdata;
      e.tag   = tag;
      e.we    = we;
      e.err   = exp_err;
      exp_q.push_back(e);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_tag   = tag;
      @(posedge clk); #1;
      req_valid = 1'b0;
      k = 1;
      while (rsp_valid !== 1'b1 && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      check("rsp_latency", 32'(k), 32'(LATENCY + 1));
   endtask

   // Called in the first cycle with reset released; counts cycles until ready.
   task automatic init_count();
      int n = 0;
      check("init_done_low", 32'(init_done), 32'd0);
      while (req_ready !== 1'b1 && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      check("init_cycles", 32'(n), 32'(DEPTH));
      check("init_done_high", 32'(init_done), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rsp_t e;
      int   t;
      reset     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_tag   = '0;
      rsp_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs",
            32'({req_ready, rsp_valid, rsp_rdata, rsp_tag, rsp_we, rsp_err, init_done}), 32'd0);

      reset = 1'b1;
      init_count();

      // Cleared store, then store/load round trip.
      do_req(1'b0, 16'd5, 16'h0000, 4'd7, 16'h0000, 1'b0);
      do_req(1'b1, 16'd4, 16'hA505, 4'd0, 16'h0000, 1'b0);
      do_req(1'b0, 16'd4, 16'h0000, 4'd3, 16'hA505, 1'b0);

      // Backpressure: rsp_ready low in cycles 3..7, released in cycle 8.
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      do_req(1'b0, 16'd4, 16'h0000, 4'd9, 16'hA505, 1'b0);
      for (int i = 0; i < 6; i++) begin
         if (i == 5) rsp_ready = 1'b1;
         check("bp_valid",     32'(rsp_valid), 32'd1);
         check("bp_rdata",     32'(rsp_rdata), 32'h0000A505);
         check("bp_tag",       32'(rsp_tag),   32'd9);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      check("bp_single_handshake", 32'(rsp_valid), 32'd0);
      check("bp_popped", 32'(exp_q.size()), 32'd0);

      // Out-of-range requests and no wrap-around write.
      do_req(1'b1, 16'd16,    16'h1234, 4'd5,  16'h0000, 1'b1);
      do_req(1'b0, 16'd16,    16'h0000, 4'd6,  16'h0000, 1'b1);
      do_req(1'b0, 16'd0,     16'h0000, 4'd8,  16'h0000, 1'b0);
      do_req(1'b0, 16'hFFFF,  16'h0000, 4'd10, 16'h0000, 1'b1);

      // Reset during BUSY: store discarded, full INIT again.
      wait_ready("rst_ready_timeout");
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 16'd2;
      req_wdata = 16'hBEEF;
      req_tag   = 4'd4;
      @(posedge clk); #1;
      req_valid = 1'b0;
      reset     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         check("rst_req_ready", 32'(req_ready), 32'd0);
      end
      check("rst_init_done", 32'(init_done), 32'd0);
      reset = 1'b1;
      init_count();
      do_req(1'b0, 16'd2, 16'h0000, 4'd11, 16'h0000, 1'b0);
      do_req(1'b0, 16'd4, 16'h0000, 4'd12, 16'h0000, 1'b0);

      // Back-to-back loads with req_valid held high.
      do_req(1'b1, 16'd9, 16'h1357, 4'd1, 16'h0000, 1'b0);
      wait_ready("b2b_ready_timeout");
      e.rdata = 16'h1357; e.tag = 4'd1; e.we = 1'b0; e.err = 1'b0;
      exp_q.push_back(e);
      e.rdata = 16'h0000; e.tag = 4'd2; e.we = 1'b0; e.err = 1'b0;
      exp_q.push_back(e);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 16'd9;
      req_tag   = 4'd1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            req_addr = 16'd15;
            req_tag  = 4'd2;
         end
         if (c == 5) req_valid = 1'b0;
         check("b2b_rsp_valid", 32'(rsp_valid), 32'((c == 3) || (c == 7)));
         check("b2b_req_ready", 32'(req_ready), 32'((c == 4) || (c == 8)));
      end

      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
